serial_adder_n: RTL

//  Multi-cycle N-bit adder: S = A + B + CIN, computed CHUNK bits per clock with a registered carry.

---
 rtl/serial_adder_n.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_adder_n.sv
// Multi-cycle adder: S = A + B + CIN, CHUNK bits per clock through a registered carry.
// Optional signed-overflow output enabled by defining OVERFLOW_EN.
module serial_adder_n #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NCYC = WIDTH / CHUNK;
   localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_adder_n: CHUNK must divide WIDTH and lie in 1..WIDTH");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] a_nxt;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [CHUNK-1:0] sum;
   logic             c_out;

   // a_sh doubles as the result accumulator: each chunk sum enters from the MSB side as the
   // consumed operand bits leave at the LSB side, so after NCYC steps it holds the full sum.
   always_comb begin
      {c_out, sum} = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
      a_nxt = WIDTH'({sum, a_sh} >> CHUNK);
   end

`ifdef OVERFLOW_EN
   logic c_msb;
   // Carry into the top bit of the current chunk; on the last step that is bit WIDTH-1.
   assign c_msb = sum[CHUNK-1] ^ a_sh[CHUNK-1] ^ b_sh[CHUNK-1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         busy    <= 1'b0;
         done    <= 1'b0;
         s       <= '0;
         cout    <= 1'b0;
         a_sh    <= '0;
         b_sh    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef OVERFLOW_EN
         ovf     <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done <= 1'b0;
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               a_sh    <= a_nxt;
               b_sh    <= b_sh >> CHUNK;
               carry_q <= c_out;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CW'(NCYC - 1)) begin
                  s       <= a_nxt;
                  cout    <= c_out;
`ifdef OVERFLOW_EN
                  ovf     <= c_msb ^ c_out;
`endif
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= StDone;
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
